wts_envelope_scheduler: RTL and testbench
=========================================

# wts_envelope_scheduler

Time-multiplexed envelope context store and key-event scheduler for the wave table sound engine. It holds the per-channel ADSR context (counter, state, level) for `CH_NUM` channels and steps a slot pointer through them. For each slot it presents the stored context and any pending key event to the shared combinational envelope generator, then writes the generator's result back. It also latches host key commands as per-channel pending events and streams each slot's updated level to the mixer.

## Interface

Parameters:
- `CH_NUM`, 6, number of channels (2..8).
- `CH_BITS`, 3, slot index width; requires 2^`CH_BITS` >= `CH_NUM`.

Ports:
- `clk`  in  1  system clock.
- `nreset`  in  1  asynchronous reset, active-low.
- `active`  in  1  slot-step enable; one envelope update per cycle where high.
- `host_key_on`  in  1  pulse; request key-on for `host_ch`.
- `host_key_release`  in  1  pulse; request release for `host_ch`.
- `host_key_off`  in  1  pulse; request hard off for `host_ch`.
- `host_ch`  in  `CH_BITS`  target channel of the host request.
- `slot_ch`  out  `CH_BITS`  channel currently presented to the generator.
- `eg_key_on`, `eg_key_release`, `eg_key_off`  out  1 each  key pulses to the generator.
- `eg_counter_in`  out  20  stored counter of `slot_ch`.
- `eg_state_in`  out  3  stored state of `slot_ch`.
- `eg_level_in`  out  7  stored level of `slot_ch`.
- `eg_counter_out`  in  20  next counter from the generator.
- `eg_state_out`  in  3  next state from the generator.
- `eg_level_out`  in  7  next level from the generator (0..64).
- `level_valid`  out  1  one-cycle strobe; `level_ch`/`level` were updated.
- `level_ch`  out  `CH_BITS`  channel of the last write-back.
- `level`  out  7  level written at the last write-back.
- `key_active`  out  `CH_NUM`  bit c is 1 while stored state of channel c is nonzero.

## Operation

- Storage: per channel, counter[19:0], state[2:0], level[6:0], and pending[1:0]. Pending encoding: 0 = none, 1 = on, 2 = release, 3 = off.
- Slot pointer:
  - Advances `slot_ch` to the next channel on every clock edge with `active`=1.
  - Wraps from `CH_NUM`-1 to 0.
  - Holds when `active`=0.
- Presentation (combinational): `eg_*_in` always reflect the stored context of `slot_ch`.
- Key pulse outputs:
  - Each `eg_key_*` output is high only when `active`=1 and pending[`slot_ch`] holds the matching code.
  - At most one of the three is high in any cycle.
- Write-back: on an edge with `active`=1, channel `slot_ch` stores `eg_counter_out`, `eg_level_out` and `eg_state_out`.
  - If `eg_state_out` > 4, state 0 is stored instead (illegal-state guard).
  - pending[`slot_ch`] is cleared.
- Host requests:
  - A request with `host_ch` < `CH_NUM` writes pending[`host_ch`] on the next edge, regardless of `active`.
  - Requests with `host_ch` >= `CH_NUM` are ignored.
  - If several host pulses are high together, priority is off > on > release.
  - A newer request overwrites an older undelivered one (last write wins).
- Simultaneous host write and delivery on the same channel: the host write wins. The new code is stored, the delivered one is cleared, and the new event goes out on the next visit.
- Level stream:
  - On each write-back edge, `level_valid` goes to 1 for one cycle, `level_ch` takes the old `slot_ch`, and `level` takes `eg_level_out`.
  - `level_ch` and `level` hold their values otherwise.
- `key_active` is registered and derived from the stored states.

## Timing

- Reset (asynchronous, `nreset`=0): all contexts and pending are 0, `slot_ch`=0, `level_valid`=0, `level_ch`=0, `level`=0, `key_active`=0.
- Outputs that follow from reset state: `eg_*_in` are 0 and `eg_key_*` are 0.
- Reset mid-operation discards all pending events immediately.
- Generator loop: zero-cycle combinational. `eg_*_out` must settle within the same cycle.
- Host latency: a request taken at edge t is delivered on the first `active` cycle after t in which `slot_ch` equals the target channel. Worst case is `CH_NUM` active cycles.
- `level_valid` follows the write-back edge by 0 cycles, i.e. it is registered on that edge.
- With `active` held high, each channel is updated once every `CH_NUM` cycles.

## Test plan

- Reset: with `nreset` low mid-run, all outputs are 0 immediately; after release with `active`=1, `slot_ch` runs 0,1,…,5,0.
- Key-on delivery: with `CH_NUM`=6, `slot_ch`=1 and a key-on pulse for ch3, `eg_key_on`=1 only in the cycle where `slot_ch`=3. A generator stub returning state 1 and level 5 gives `level_valid` with `level_ch`=3 and `level`=5, then `key_active`[3]=1.
- Overwrite: a key-on then a key-off to ch2 before its slot produces only `eg_key_off` at slot 2. Same-cycle host pulses on+release produce only the on event.
- Collision: a host key-release to ch4 on the same edge ch4 delivers a key-on. Key-on is seen, then key-release is delivered on the next visit, 6 active cycles later.
- Hold: with `active`=0 for 10 cycles, `slot_ch`, the contexts and `level_valid`=0 are unchanged. A pending event stays queued and is delivered when `active` returns.
- Guard and range: a stub returning state 7 makes the stored state read back 0. A request with `host_ch`=7 changes no pending.

Source files
------------

// File: rtl/wts_envelope_scheduler_if.sv
// Bus bundle for the envelope scheduler: host key requests, the shared
// generator loop and the per-slot level stream toward the mixer.
interface wts_envelope_scheduler_if #(
  parameter int CH_NUM  = 6,
  parameter int CH_BITS = 3
);
  logic                active;
  logic                host_key_on;
  logic                host_key_release;
  logic                host_key_off;
  logic [CH_BITS-1:0]  host_ch;

  logic [CH_BITS-1:0]  slot_ch;
  logic                eg_key_on;
  logic                eg_key_release;
  logic                eg_key_off;
  logic [19:0]         eg_counter_in;
  logic [2:0]          eg_state_in;
  logic [6:0]          eg_level_in;
  logic [19:0]         eg_counter_out;
  logic [2:0]          eg_state_out;
  logic [6:0]          eg_level_out;

  // level_valid is a one-cycle strobe with no ready: the mixer must take
  // level_ch/level on the cycle it is high; both hold until the next strobe.
  logic                level_valid;
  logic [CH_BITS-1:0]  level_ch;
  logic [6:0]          level;
  logic [CH_NUM-1:0]   key_active;

  modport master (
    output active, host_key_on, host_key_release, host_key_off, host_ch,
           eg_counter_out, eg_state_out, eg_level_out,
    input  slot_ch, eg_key_on, eg_key_release, eg_key_off,
           eg_counter_in, eg_state_in, eg_level_in,
           level_valid, level_ch, level, key_active
  );

  modport slave (
    input  active, host_key_on, host_key_release, host_key_off, host_ch,
           eg_counter_out, eg_state_out, eg_level_out,
    output slot_ch, eg_key_on, eg_key_release, eg_key_off,
           eg_counter_in, eg_state_in, eg_level_in,
           level_valid, level_ch, level, key_active
  );
endinterface

// File: rtl/wts_envelope_scheduler.sv
// Time-multiplexed ADSR context store: steps a slot pointer over the channels,
// feeds the shared envelope generator and writes its result back.
module wts_envelope_scheduler #(
  parameter int CH_NUM  = 6,
  parameter int CH_BITS = 3
) (
  input  logic                   clk,
  input  logic                   nreset,
  wts_envelope_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    PEND_NONE    = 2'd0,
    PEND_ON      = 2'd1,
    PEND_RELEASE = 2'd2,
    PEND_OFF     = 2'd3
  } pend_t;

  localparam int               CH_NUM_I  = CH_NUM;
  localparam logic [CH_BITS:0] CH_LIMIT  = CH_NUM_I[CH_BITS:0];
  localparam logic [CH_BITS-1:0] LAST_SLOT = CH_BITS'(CH_NUM - 1);

  logic [19:0]        counter_q [CH_NUM];
  logic [2:0]         state_q   [CH_NUM];
  logic [6:0]         level_q   [CH_NUM];
  pend_t              pending_q [CH_NUM];

  logic [CH_BITS-1:0] slot_q;
  logic               level_valid_q;
  logic [CH_BITS-1:0] level_ch_q;
  logic [6:0]         level_lvl_q;
  logic [CH_NUM-1:0]  key_active_q;

  pend_t              pend_cur;
  pend_t              host_code;
  logic               host_hit;
  logic [2:0]         state_wb;

  always_comb begin
    pend_cur  = pending_q[slot_q];
    host_hit  = (bus.host_key_on || bus.host_key_release || bus.host_key_off) &&
                ({1'b0, bus.host_ch} < CH_LIMIT);
    // Off outranks on, which outranks release, when pulses coincide.
    host_code = bus.host_key_off ? PEND_OFF :
                bus.host_key_on  ? PEND_ON  : PEND_RELEASE;
    // States above 4 do not exist; treat them as idle.
    state_wb  = (bus.eg_state_out > 3'd4) ? 3'd0 : bus.eg_state_out;
  end

  assign bus.slot_ch        = slot_q;
  assign bus.eg_counter_in  = counter_q[slot_q];
  assign bus.eg_state_in    = state_q[slot_q];
  assign bus.eg_level_in    = level_q[slot_q];
  assign bus.eg_key_on      = bus.active && (pend_cur == PEND_ON);
  assign bus.eg_key_release = bus.active && (pend_cur == PEND_RELEASE);
  assign bus.eg_key_off     = bus.active && (pend_cur == PEND_OFF);
  assign bus.level_valid    = level_valid_q;
  assign bus.level_ch       = level_ch_q;
  assign bus.level          = level_lvl_q;
  assign bus.key_active     = key_active_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int c = 0; c < CH_NUM; c++) begin
        counter_q[c] <= '0;
        state_q[c]   <= '0;
        level_q[c]   <= '0;
        pending_q[c] <= PEND_NONE;
      end
      slot_q        <= '0;
      level_valid_q <= 1'b0;
      level_ch_q    <= '0;
      level_lvl_q   <= '0;
      key_active_q  <= '0;
    end else begin
      level_valid_q <= bus.active;
      if (bus.active) begin
        counter_q[slot_q] <= bus.eg_counter_out;
        state_q[slot_q]   <= state_wb;
        level_q[slot_q]   <= bus.eg_level_out;
        pending_q[slot_q] <= PEND_NONE;
        slot_q            <= (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        level_ch_q        <= slot_q;
        level_lvl_q       <= bus.eg_level_out;
      end
      // Placed after the delivery clear so a host write on the same channel wins.
      if (host_hit) begin
        pending_q[bus.host_ch] <= host_code;
      end
      // Mirrors the state array as it stands after this edge.
      for (int c = 0; c < CH_NUM; c++) begin
        if (bus.active && (slot_q == CH_BITS'(c))) begin
          key_active_q[c] <= (state_wb != 3'd0);
        end else begin
          key_active_q[c] <= (state_q[c] != 3'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_wts_envelope_scheduler.sv
// Randomized bench for wts_envelope_scheduler: a behavioural channel model
// predicts presentation, key pulses, level stream and key_active.
module tb_wts_envelope_scheduler;
  localparam int CH_NUM  = 6;
  localparam int CH_BITS = 3;

  logic clk;
  logic nreset;

  wts_envelope_scheduler_if #(.CH_NUM(CH_NUM), .CH_BITS(CH_BITS)) bus ();

  wts_envelope_scheduler #(.CH_NUM(CH_NUM), .CH_BITS(CH_BITS)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: per-channel context and queued key event (0 none,1 on,2 release,3 off)
  logic [19:0] m_counter [CH_NUM];
  int          m_state   [CH_NUM];
  int          m_level   [CH_NUM];
  int          m_pending [CH_NUM];
  int          m_slot;

  logic [9:0]  exp_q[$];
  logic [9:0]  last_lvl;
  logic        exp_valid;
  logic        mon_en;

  int n_checks;
  int n_pass;

  logic        act, hon, hrel, hoff;
  logic [2:0]  hch;
  logic [19:0] e_cnt;
  logic [2:0]  e_st;
  logic [6:0]  e_lv;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH_NUM; c++) begin
      m_counter[c] = '0;
      m_state[c]   = 0;
      m_level[c]   = 0;
      m_pending[c] = 0;
    end
    m_slot    = 0;
    exp_q.delete();
    last_lvl  = '0;
    exp_valid = 1'b0;
  endtask

  task automatic drive_idle();
    act = 1'b0; hon = 1'b0; hrel = 1'b0; hoff = 1'b0; hch = '0;
    e_cnt = '0; e_st = '0; e_lv = '0;
    bus.active = 1'b0;
    bus.host_key_on = 1'b0; bus.host_key_release = 1'b0; bus.host_key_off = 1'b0;
    bus.host_ch = '0;
    bus.eg_counter_out = '0; bus.eg_state_out = '0; bus.eg_level_out = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_slot_ch"},     32'(bus.slot_ch), 0);
    chk({tag, "_eg_in"},       {bus.eg_counter_in, bus.eg_state_in, bus.eg_level_in}, 0);
    chk({tag, "_eg_keys"},     {bus.eg_key_on, bus.eg_key_release, bus.eg_key_off}, 0);
    chk({tag, "_level_out"},   {bus.level_valid, bus.level_ch, bus.level}, 0);
    chk({tag, "_key_active"},  32'(bus.key_active), 0);
  endtask

  // Asserted at a falling edge, so the bench sees the asynchronous clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    mon_en = 1'b0;
    drive_idle();
    nreset = 1'b0;
    #1;
    model_clear();
    check_all_zero(tag);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    mon_en = 1'b1;
  endtask

  // driver: one cycle of random stimulus, with presentation checked before the edge
  task automatic step(input int p_active, input int p_host);
    logic [2:0] exp_keys;
    logic [2:0] s3;
    int         code;
    @(negedge clk);
    act   = ($urandom_range(0, 99) < p_active);
    hon   = ($urandom_range(0, 99) < p_host);
    hrel  = ($urandom_range(0, 99) < p_host);
    hoff  = ($urandom_range(0, 99) < p_host / 2);
    hch   = 3'($urandom_range(0, 7));
    e_cnt = 20'($urandom);
    e_st  = 3'($urandom_range(0, 7));
    e_lv  = 7'($urandom_range(0, 64));
    bus.active = act;
    bus.host_key_on = hon; bus.host_key_release = hrel; bus.host_key_off = hoff;
    bus.host_ch = hch;
    bus.eg_counter_out = e_cnt; bus.eg_state_out = e_st; bus.eg_level_out = e_lv;
    #1;
    chk("slot_ch", 32'(bus.slot_ch), 32'(m_slot));
    chk("eg_counter_in", 32'(bus.eg_counter_in), 32'(m_counter[m_slot]));
    chk("eg_state_in", 32'(bus.eg_state_in), 32'(m_state[m_slot]));
    chk("eg_level_in", 32'(bus.eg_level_in), 32'(m_level[m_slot]));
    code = act ? m_pending[m_slot] : 0;
    exp_keys = (code == 1) ? 3'b100 : (code == 2) ? 3'b010 : (code == 3) ? 3'b001 : 3'b000;
    chk("eg_keys", {bus.eg_key_on, bus.eg_key_release, bus.eg_key_off}, 32'(exp_keys));
    s3 = m_slot[2:0];
    if (act) exp_q.push_back({s3, e_lv});
    @(posedge clk);
    exp_valid = act;
    if (act) begin
      m_counter[m_slot] = e_cnt;
      m_state[m_slot]   = (e_st > 3'd4) ? 0 : int'(e_st);
      m_level[m_slot]   = int'(e_lv);
      m_pending[m_slot] = 0;
      m_slot            = (m_slot + 1) % CH_NUM;
    end
    if ((hon || hrel || hoff) && (int'(hch) < CH_NUM))
      m_pending[hch] = hoff ? 3 : hon ? 1 : 2;
  endtask

  // monitor: level stream and key_active, sampled just after each edge
  always @(posedge clk) begin
    logic [CH_NUM-1:0] exp_ka;
    logic [9:0]        exp_l;
    #2;
    if (nreset && mon_en) begin
      chk("level_valid", 32'(bus.level_valid), 32'(exp_valid));
      if (bus.level_valid) begin
        if (exp_q.size() == 0) begin
          chk("level_unexpected", 1, 0);
        end else begin
          exp_l = exp_q.pop_front();
          chk("level_stream", {bus.level_ch, bus.level}, 32'(exp_l));
          last_lvl = exp_l;
        end
      end else begin
        chk("level_hold", {bus.level_ch, bus.level}, 32'(last_lvl));
      end
      for (int c = 0; c < CH_NUM; c++) exp_ka[c] = (m_state[c] != 0);
      chk("key_active", 32'(bus.key_active), 32'(exp_ka));
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    nreset   = 1'b0;
    drive_idle();
    model_clear();
    repeat (2) @(negedge clk);
    do_reset("reset_init");

    for (int i = 0; i < 150; i++) step(100, 25);
    for (int i = 0; i < 6; i++)   step(100, 40);
    for (int i = 0; i < 10; i++)  step(0, 30);
    for (int i = 0; i < 12; i++)  step(100, 0);

    do_reset("reset_mid");
    for (int i = 0; i < 250; i++) step(70, 35);
    for (int i = 0; i < 3; i++)   step(0, 0);
    @(negedge clk);
    chk("level_queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
